// File: rtl/axi_bresp_queue.sv
// AXI write-response (B) channel queue: buffers back-end responses in order
// and presents them on the B channel with registered VALID/RESP/ID, occupancy
// status and a saturating error-response counter.
module axi_bresp_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ID_W      = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 wr_resp_valid,
  output logic                                 wr_resp_ready,
  input  logic [1:0]                           wr_resp,
  input  logic [((ID_W > 0) ? ID_W : 1)-1:0]   wr_resp_id,
  output logic                                 BVALID,
  input  logic                                 BREADY,
  output logic [1:0]                           BRESP,
  output logic [((ID_W > 0) ? ID_W : 1)-1:0]   BID,
  output logic [$clog2(DEPTH):0]               count,
  output logic                                 full,
  output logic                                 empty,
  output logic [ERR_CNT_W-1:0]                 err_count,
  input  logic                                 err_clr
);

  localparam int unsigned IdW   = (ID_W > 0) ? ID_W : 1;
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [ERR_CNT_W-1:0] ErrMax = '1;

  logic [1:0]      resp_mem_q [DEPTH];
  logic [IdW-1:0]  id_mem_q   [DEPTH];

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 bvalid_q, bvalid_d;
  logic [1:0]           bresp_q, bresp_d;
  logic [IdW-1:0]       bid_q, bid_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;

  logic           push, pop;
  logic [IdW-1:0] id_in;

  // Handshake qualification; ready comes only from registered occupancy
  assign wr_resp_ready = !full_q;
  assign push          = wr_resp_valid && !full_q;
  assign pop           = bvalid_q && BREADY;
  assign id_in         = (ID_W > 0) ? wr_resp_id : '0;

  // Next-state: pointers, occupancy, head register (with empty-queue bypass), error counter
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + CntW'(push) - CntW'(pop);
    full_d   = (count_d == CntW'(DEPTH));
    empty_d  = (count_d == '0);
    bvalid_d = !empty_d;
    bresp_d  = bresp_q;
    bid_d    = bid_q;
    if (!empty_d) begin
      // New head is the entry being written this cycle only when nothing else remains
      if (push && (count_q - CntW'(pop) == '0)) begin
        bresp_d = wr_resp;
        bid_d   = id_in;
      end else begin
        bresp_d = resp_mem_q[rd_ptr_d];
        bid_d   = id_mem_q[rd_ptr_d];
      end
    end
    err_d = err_q;
    if (err_clr) begin
      err_d = '0;
    end else if (pop && bresp_q[1] && (err_q != ErrMax)) begin
      err_d = err_q + ERR_CNT_W'(1);
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      bid_q    <= '0;
      err_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      bid_q    <= bid_d;
      err_q    <= err_d;
    end
  end

  // Response storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push) begin
      resp_mem_q[wr_ptr_q] <= wr_resp;
      id_mem_q[wr_ptr_q]   <= id_in;
    end
  end

  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign BID       = bid_q;
  assign count     = count_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign err_count = err_q;

endmodule
